// File: rtl/axi_simple_mst.sv
// Single-outstanding AXI4 initiator: turns one command plus a data stream into one
// INCR burst, then reports the worst response and any protocol anomaly seen.
module axi_simple_mst #(
  parameter int unsigned AxiAddrWidth = 32,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned TxnId        = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [AxiAddrWidth-1:0]   cmd_addr_i,
  input  logic [7:0]                cmd_len_i,
  input  logic                      wdata_valid_i,
  output logic                      wdata_ready_o,
  input  logic [AxiDataWidth-1:0]   wdata_i,
  output logic                      rdata_valid_o,
  input  logic                      rdata_ready_i,
  output logic [AxiDataWidth-1:0]   rdata_o,
  output logic                      rdata_last_o,
  output logic                      done_valid_o,
  input  logic                      done_ready_i,
  output logic [1:0]                done_resp_o,
  output logic                      done_err_o,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [AxiIdWidth-1:0]     aw_id_o,
  output logic [AxiAddrWidth-1:0]   aw_addr_o,
  output logic [7:0]                aw_len_o,
  output logic [2:0]                aw_size_o,
  output logic [1:0]                aw_burst_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [AxiDataWidth-1:0]   w_data_o,
  output logic [AxiDataWidth/8-1:0] w_strb_o,
  output logic                      w_last_o,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [AxiIdWidth-1:0]     b_id_i,
  input  logic [1:0]                b_resp_i,
  output logic                      ar_valid_o,
  input  logic                      ar_ready_i,
  output logic [AxiIdWidth-1:0]     ar_id_o,
  output logic [AxiAddrWidth-1:0]   ar_addr_o,
  output logic [7:0]                ar_len_o,
  output logic [2:0]                ar_size_o,
  output logic [1:0]                ar_burst_o,
  input  logic                      r_valid_i,
  output logic                      r_ready_o,
  input  logic [AxiIdWidth-1:0]     r_id_i,
  input  logic [AxiDataWidth-1:0]   r_data_i,
  input  logic [1:0]                r_resp_i,
  input  logic                      r_last_i,
  output logic [2:0]                state_o
);

  // Handshake rule on every channel: a beat transfers on the rising clock edge
  // where valid and ready are both high; valid never waits on ready.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAw   = 3'd1;
  localparam logic [2:0] StW    = 3'd2;
  localparam logic [2:0] StB    = 3'd3;
  localparam logic [2:0] StAr   = 3'd4;
  localparam logic [2:0] StR    = 3'd5;
  localparam logic [2:0] StDone = 3'd6;

  localparam logic [AxiIdWidth-1:0] TxnIdL = AxiIdWidth'(TxnId);
  localparam logic [2:0]            AxSize = 3'($clog2(AxiDataWidth / 8));

  logic [2:0]              state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [1:0]              resp_q;
  logic                    err_q;
  logic                    terminal;
  logic                    w_hs, b_hs, r_hs;

  // Response codes are ordered by severity, so the worst is the numeric max.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign terminal = (beat_q == len_q);
  assign w_hs     = w_valid_o & w_ready_i;
  assign b_hs     = b_valid_i & b_ready_o;
  assign r_hs     = r_valid_i & r_ready_o;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_valid_i) state_d = cmd_write_i ? StAw : StAr;
      StAw:   if (aw_ready_i) state_d = StW;
      StW:    if (w_hs && terminal) state_d = StB;
      StB:    if (b_valid_i) state_d = StDone;
      StAr:   if (ar_ready_i) state_d = StR;
      StR:    if (r_hs && terminal) state_d = StDone;
      StDone: if (done_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cmd_valid_i) begin
        addr_q <= cmd_addr_i;
        len_q  <= cmd_len_i;
        beat_q <= '0;
        resp_q <= '0;
        err_q  <= 1'b0;
      end
      if (w_hs) beat_q <= beat_q + 8'd1;
      if (b_hs) begin
        resp_q <= worst(resp_q, b_resp_i);
        if (b_id_i != TxnIdL) err_q <= 1'b1;
      end
      // The beat counter, not r_last, decides the end of a read burst.
      if (r_hs) begin
        beat_q <= beat_q + 8'd1;
        resp_q <= worst(resp_q, r_resp_i);
        if (r_id_i != TxnIdL || r_last_i != rdata_last_o) err_q <= 1'b1;
      end
    end
  end

  assign cmd_ready_o   = (state_q == StIdle);

  assign aw_valid_o    = (state_q == StAw);
  assign aw_id_o       = TxnIdL;
  assign aw_addr_o     = addr_q;
  assign aw_len_o      = len_q;
  assign aw_size_o     = AxSize;
  assign aw_burst_o    = 2'b01;

  assign w_valid_o     = (state_q == StW) & wdata_valid_i;
  assign wdata_ready_o = (state_q == StW) & w_ready_i;
  assign w_data_o      = wdata_i;
  assign w_strb_o      = '1;
  assign w_last_o      = (state_q == StW) & terminal;

  assign b_ready_o     = (state_q == StB);

  assign ar_valid_o    = (state_q == StAr);
  assign ar_id_o       = TxnIdL;
  assign ar_addr_o     = addr_q;
  assign ar_len_o      = len_q;
  assign ar_size_o     = AxSize;
  assign ar_burst_o    = 2'b01;

  assign r_ready_o     = (state_q == StR) & rdata_ready_i;
  assign rdata_valid_o = (state_q == StR) & r_valid_i;
  assign rdata_o       = r_data_i;
  assign rdata_last_o  = (state_q == StR) & terminal;

  assign done_valid_o  = (state_q == StDone);
  assign done_resp_o   = resp_q;
  assign done_err_o    = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_axi_simple_mst.sv
// Bench for axi_simple_mst: directed write/read bursts against a scripted slave,
// with expected AW/AR, W, read-data and completion records checked by a monitor.
module tb_axi_simple_mst;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid_i = 0, cmd_write_i = 0;
  logic [31:0] cmd_addr_i = '0;
  logic [7:0]  cmd_len_i = '0;
  logic        cmd_ready_o;
  logic        wdata_valid_i = 0;
  logic [63:0] wdata_i = '0;
  logic        wdata_ready_o;
  logic        rdata_valid_o, rdata_ready_i = 1, rdata_last_o;
  logic [63:0] rdata_o;
  logic        done_valid_o, done_ready_i = 1, done_err_o;
  logic [1:0]  done_resp_o;
  logic        aw_valid_o, aw_ready_i = 1;
  logic [3:0]  aw_id_o;
  logic [31:0] aw_addr_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic [1:0]  aw_burst_o;
  logic        w_valid_o, w_ready_i = 1, w_last_o;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        b_valid_i = 0, b_ready_o;
  logic [3:0]  b_id_i = '0;
  logic [1:0]  b_resp_i = '0;
  logic        ar_valid_o, ar_ready_i = 1;
  logic [3:0]  ar_id_o;
  logic [31:0] ar_addr_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid_i = 0, r_ready_o, r_last_i = 0;
  logic [3:0]  r_id_i = '0;
  logic [63:0] r_data_i = '0;
  logic [1:0]  r_resp_i = '0;
  logic [2:0]  state_dbg;

  axi_simple_mst dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .rdata_last_o(rdata_last_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_resp_o(done_resp_o),
    .done_err_o(done_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_id_i(b_id_i), .b_resp_i(b_resp_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_id_i(r_id_i), .r_data_i(r_data_i),
    .r_resp_i(r_resp_i), .r_last_i(r_last_i),
    .state_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [40:0] exp_addr_q[$];  // {write, addr, len}
  logic [64:0] exp_w_q[$];     // {last, data}
  logic [64:0] exp_rd_q[$];    // {last, data}
  logic [2:0]  exp_done_q[$];  // {err, resp}
  logic [1:0]  r_resp_v[16];
  logic        r_last_v[16];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected none", name, what);
  endtask

  function automatic logic [63:0] wbeat(input logic [31:0] a, input int i);
    return {a, 16'hBEEF, 8'h00, 8'(i)};
  endfunction

  function automatic logic [63:0] rbeat(input logic [31:0] a, input int i);
    return {~a, 16'hCAFE, 8'h00, 8'(i)};
  endfunction

  // Monitor: pops one expected record per handshake seen on each output channel.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (aw_valid_o && aw_ready_i) begin
        if (exp_addr_q.size() == 0) fail_event("aw_req", "unexpected AW");
        else check("aw_req", 96'({1'b1, aw_addr_o, aw_len_o}), 96'(exp_addr_q.pop_front()));
        check("aw_fixed", 96'({aw_id_o, aw_size_o, aw_burst_o}), 96'({4'd0, 3'd3, 2'b01}));
      end
      if (ar_valid_o && ar_ready_i) begin
        if (exp_addr_q.size() == 0) fail_event("ar_req", "unexpected AR");
        else check("ar_req", 96'({1'b0, ar_addr_o, ar_len_o}), 96'(exp_addr_q.pop_front()));
        check("ar_fixed", 96'({ar_id_o, ar_size_o, ar_burst_o}), 96'({4'd0, 3'd3, 2'b01}));
      end
      if (w_valid_o && w_ready_i) begin
        if (exp_w_q.size() == 0) fail_event("w_beat", "unexpected W");
        else check("w_beat", 96'({w_last_o, w_data_o}), 96'(exp_w_q.pop_front()));
        check("w_strb", 96'(w_strb_o), 96'(8'hFF));
      end
      if (rdata_valid_o) check("r_ready_track", 96'(r_ready_o), 96'(rdata_ready_i));
      if (rdata_valid_o && rdata_ready_i) begin
        if (exp_rd_q.size() == 0) fail_event("rdata_beat", "unexpected rdata");
        else check("rdata_beat", 96'({rdata_last_o, rdata_o}), 96'(exp_rd_q.pop_front()));
      end
      if (done_valid_o && done_ready_i) begin
        if (exp_done_q.size() == 0) fail_event("done", "unexpected done");
        else check("done", 96'({done_err_o, done_resp_o}), 96'(exp_done_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1; also checks the 1-cycle command-to-valid latency.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    cmd_valid_i = 1; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
    exp_addr_q.push_back({wr, addr, len});
    @(negedge clk);
    while (!cmd_ready_o && n < 200) begin n++; @(negedge clk); end
    if (!cmd_ready_o) fail_event("cmd_accept", "timeout");
    tick();
    cmd_valid_i = 0;
    @(negedge clk);
    if (wr) check("aw_valid_latency", 96'(aw_valid_o), 96'(1));
    else    check("ar_valid_latency", 96'(ar_valid_o), 96'(1));
    check("cmd_ready_busy", 96'(cmd_ready_o), 96'(0));
    tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_done_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_done_q.size() != 0) fail_event("done_wait", "timeout");
    tick();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bresp,
                          input logic [3:0] bid, input logic [2:0] exp_done, input int aw_stall,
                          input bit hold_done);
    exp_done_q.push_back(exp_done);
    done_ready_i = !hold_done;
    aw_ready_i = (aw_stall == 0);
    wdata_i = wbeat(addr, 0);
    wdata_valid_i = 1;
    issue_cmd(1'b1, addr, len);
    if (aw_stall > 0) begin
      b_valid_i = 1; b_resp_i = 2'd3; b_id_i = bid;
      repeat (aw_stall) begin
        @(negedge clk);
        check("early_w_blocked", 96'({wdata_ready_o, w_valid_o}), 96'(0));
        check("early_b_blocked", 96'(b_ready_o), 96'(0));
        check("aw_valid_held", 96'({aw_valid_o, aw_addr_o, aw_len_o}), 96'({1'b1, addr, len}));
        tick();
      end
      b_valid_i = 0;
      aw_ready_i = 1;
    end
    fork
      begin
        int n;
        for (int i = 0; i <= int'(len); i++) begin
          logic lst;
          lst = (i == int'(len));
          wdata_i = wbeat(addr, i);
          wdata_valid_i = 1;
          exp_w_q.push_back({lst, wdata_i});
          n = 0;
          @(negedge clk);
          while (!wdata_ready_o && n < 300) begin n++; @(negedge clk); end
          if (!wdata_ready_o) fail_event("w_accept", "timeout");
          if (i > 0) check("w_throughput_stalls", 96'(n), 96'(0));
          tick();
        end
        wdata_valid_i = 0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!(w_valid_o && w_ready_i && w_last_o) && n < 600) begin n++; @(negedge clk); end
        if (!(w_valid_o && w_ready_i && w_last_o)) fail_event("w_last_seen", "timeout");
        else begin
          tick();
          b_valid_i = 1; b_id_i = bid; b_resp_i = bresp;
          @(negedge clk);
          check("b_ready_latency", 96'(b_ready_o), 96'(1));
          tick();
          b_valid_i = 0;
          @(negedge clk);
          check("done_latency", 96'(done_valid_o), 96'(1));
          tick();
        end
      end
    join
    if (hold_done) begin
      repeat (3) begin
        @(negedge clk);
        check("done_held", 96'({done_valid_o, cmd_ready_o}), 96'(2'b10));
      end
      tick();
      done_ready_i = 1;
    end
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] exp_done, input bit stall);
    bit r_done;
    r_done = 0;
    exp_done_q.push_back(exp_done);
    ar_ready_i = 1;
    rdata_ready_i = 1;
    issue_cmd(1'b0, addr, len);
    fork
      begin
        int n;
        for (int i = 0; i <= int'(len); i++) begin
          logic lst;
          lst = (i == int'(len));
          if (stall) begin
            r_valid_i = 0;
            repeat ($urandom_range(0, 2)) tick();
          end
          r_valid_i = 1; r_id_i = 4'd0; r_data_i = rbeat(addr, i);
          r_resp_i = r_resp_v[i]; r_last_i = r_last_v[i];
          exp_rd_q.push_back({lst, r_data_i});
          n = 0;
          @(negedge clk);
          while (!r_ready_o && n < 200) begin n++; @(negedge clk); end
          if (!r_ready_o) fail_event("r_accept", "timeout");
          tick();
        end
        r_valid_i = 0; r_last_i = 0;
        r_done = 1;
      end
      begin
        if (stall) begin
          while (!r_done) begin
            rdata_ready_i = 1'($urandom_range(0, 1));
            tick();
          end
          rdata_ready_i = 1;
        end
      end
    join
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin r_resp_v[i] = 2'd0; r_last_v[i] = 1'b0; end

    // Reset values
    #2;
    check("reset_cmd_ready", 96'(cmd_ready_o), 96'(1));
    check("reset_valids", 96'({aw_valid_o, w_valid_o, wdata_ready_o, b_ready_o, ar_valid_o,
                                r_ready_o, rdata_valid_o, done_valid_o}), 96'(0));
    check("reset_regs", 96'({aw_addr_o, aw_len_o, aw_id_o, ar_addr_o, ar_len_o, done_resp_o,
                             done_err_o}), 96'(0));
    repeat (3) @(posedge clk);
    #1 rst_ni = 1;
    tick();

    // Write 4 beats, OKAY; AW stalled with early W and early B offered; done held off
    do_write(32'h0000_1000, 8'd3, 2'd0, 4'd0, 3'b0_00, 2, 1'b1);

    // Read 1 beat from the decode-error slave
    r_resp_v[0] = 2'd3; r_last_v[0] = 1'b1;
    do_read(32'h0000_2000, 8'd0, 3'b0_11, 1'b0);

    // Read 8 beats with random stalls on both sides
    for (int i = 0; i < 8; i++) begin r_resp_v[i] = 2'd0; r_last_v[i] = (i == 7); end
    do_read(32'h0000_3000, 8'd7, 3'b0_00, 1'b1);

    // Read 4 beats, slave raises r_last early on beat 2 and not on beat 4
    r_last_v[0] = 0; r_last_v[1] = 1; r_last_v[2] = 0; r_last_v[3] = 0;
    for (int i = 0; i < 4; i++) r_resp_v[i] = 2'd0;
    do_read(32'h0000_4000, 8'd3, 3'b1_00, 1'b0);

    // Mixed responses: write SLVERR, then read OKAY/EXOKAY/OKAY
    do_write(32'h0000_5000, 8'd1, 2'd2, 4'd0, 3'b0_10, 0, 1'b0);
    r_resp_v[0] = 2'd0; r_resp_v[1] = 2'd1; r_resp_v[2] = 2'd0;
    r_last_v[0] = 0; r_last_v[1] = 0; r_last_v[2] = 1;
    do_read(32'h0000_6000, 8'd2, 3'b0_01, 1'b0);

    // Single-beat write with a foreign B id
    do_write(32'h0000_5800, 8'd0, 2'd0, 4'd5, 3'b1_00, 0, 1'b0);

    // Longest burst: 256 beats through the 8-bit counter
    do_write(32'h0001_0000, 8'd255, 2'd1, 4'd0, 3'b0_01, 0, 1'b0);

    // Reset in the middle of a 16-beat write, after 5 beats
    aw_ready_i = 1;
    issue_cmd(1'b1, 32'h0000_7000, 8'd15);
    for (int i = 0; i < 5; i++) begin
      wdata_i = wbeat(32'h0000_7000, i);
      wdata_valid_i = 1;
      exp_w_q.push_back({1'b0, wdata_i});
      @(negedge clk);
      check("mid_w_ready", 96'(wdata_ready_o), 96'(1));
      tick();
    end
    wdata_i = wbeat(32'h0000_7000, 5);
    #2 rst_ni = 0;
    #1;
    check("async_reset_valids", 96'({aw_valid_o, w_valid_o, wdata_ready_o, b_ready_o, ar_valid_o,
                                      r_ready_o, rdata_valid_o, done_valid_o}), 96'(0));
    check("async_reset_cmd_ready", 96'(cmd_ready_o), 96'(1));
    wdata_valid_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1;
    @(negedge clk);
    check("post_reset_cmd_ready", 96'(cmd_ready_o), 96'(1));
    check("post_reset_queues", 96'({8'(exp_addr_q.size()), 8'(exp_w_q.size()),
                                    8'(exp_done_q.size())}), 96'(0));
    tick();

    // A normal read after the reset
    r_resp_v[0] = 2'd0; r_last_v[0] = 0; r_resp_v[1] = 2'd0; r_last_v[1] = 1;
    do_read(32'h0000_8000, 8'd1, 3'b0_00, 1'b0);

    repeat (3) tick();
    check("drain_queues", 96'({8'(exp_addr_q.size()), 8'(exp_w_q.size()), 8'(exp_rd_q.size()),
                               8'(exp_done_q.size())}), 96'(0));
    check("final_idle", 96'({cmd_ready_o, done_valid_o}), 96'(2'b10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
